// File: rtl/aes_pkg.sv
// Shared AES column-mixing helpers: GF(2^8) arithmetic, coefficient sets and
// the FSM state encoding used by the iterative MixColumns engine.
package aes_pkg;

  localparam int NB = 4;

  // Row coefficients applied to a_r, a_{r+1}, a_{r+2}, a_{r+3}.
  localparam logic [7:0] FWD_COEF [NB] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] INV_COEF [NB] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the constants that appear in the two coefficient sets are supported.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] res;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h01:   res = x;
      8'h02:   res = x2;
      8'h03:   res = x2 ^ x;
      8'h09:   res = x8 ^ x;
      8'h0b:   res = x8 ^ x2 ^ x;
      8'h0d:   res = x8 ^ x4 ^ x;
      8'h0e:   res = x8 ^ x4 ^ x2;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns.
// Byte 0 (row 0) sits in col_in[31:24].
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] w_a [NB];
  logic [7:0] w_c [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      assign w_a[gi] = col_in[31-8*gi -: 8];
      assign w_c[gi] = inv ? INV_COEF[gi] : FWD_COEF[gi];
    end

    // Row r rotates the same coefficient vector across the column bytes.
    for (genvar gi = 0; gi < NB; gi++) begin : g_row
      logic [7:0] w_b;
      assign w_b = gmul(w_a[gi],          w_c[0]) ^
                   gmul(w_a[(gi+1) % NB], w_c[1]) ^
                   gmul(w_a[(gi+2) % NB], w_c[2]) ^
                   gmul(w_a[(gi+3) % NB], w_c[3]);
      assign col_out[31-8*gi -: 8] = w_b;
    end
  endgenerate

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: accepts a state, transforms COLS_PER_CYCLE
// columns per cycle through shared units, then holds the result until taken.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] IDX_LAST = 2'(NB - COLS_PER_CYCLE);
  // Masking a column number with this yields the index of its group's first column.
  localparam logic [1:0] GRP_MASK = 2'(NB - COLS_PER_CYCLE);

  state_t r_state;
  state_t w_state_next;

  // Ascending packed range: element 0 is the most significant word = column 0.
  logic [0:NB-1][31:0] r_data;
  logic [0:NB-1][31:0] r_out;
  logic [0:NB-1][31:0] w_data_next;
  logic                r_inv;
  logic [1:0]          r_idx;
  logic                w_last;

  logic [31:0] w_col_out [COLS_PER_CYCLE];

  assign w_last = (r_idx == IDX_LAST);

  generate
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
      logic [1:0] w_col_idx;
      assign w_col_idx = r_idx + 2'(gi);
      mix_column_unit u_col (
        .col_in  (r_data[w_col_idx]),
        .inv     (r_inv),
        .col_out (w_col_out[gi])
      );
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      logic w_in_group;
      assign w_in_group       = ((2'(gi) & GRP_MASK) == r_idx);
      assign w_data_next[gi]  = w_in_group ? w_col_out[gi % COLS_PER_CYCLE] : r_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_out  <= '0;
      r_inv  <= 1'b0;
      r_idx  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_inv  <= in_inv;
            r_idx  <= 2'd0;
          end
        end
        RUN: begin
          r_data <= w_data_next;
          r_idx  <= r_idx + IDX_STEP;
          if (w_last) begin
            r_out <= w_data_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq: FIPS-197 round data, single-column
// vectors, backpressure and reset during a running transform.
module tb_mix_columns_seq;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Presents one state and returns just after the accept edge; the inputs are
  // then scrambled so that any late sampling by the DUT shows up in the result.
  task automatic start_block(input logic [127:0] d, input logic inv, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
      ok = 1'b1;
    end
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_data  = ~d;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    ok = out_valid;
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    $display("txn reset: in_ready=%b out_valid=%b busy=%b out_data=%h", in_ready, out_valid, busy, out_data);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    bit ok;
    int cyc;
    start_block(FIPS_IN, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_accept: in_ready never high"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fwd_run_flags: got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready); end
    wait_done(cyc, ok);
    checks++; if (!ok || cyc != LAT) begin errors++; $display("FAIL fwd_latency: got %0d cycles (valid=%b) want %0d", cyc, ok, LAT); end
    checks++; if (out_data !== FIPS_OUT) begin errors++; $display("FAIL fwd_data: got %h want %h", out_data, FIPS_OUT); end
    $display("txn forward: in=%h out=%h latency=%0d", FIPS_IN, out_data, cyc);
    take_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fwd_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_inverse();
    bit ok;
    int cyc;
    start_block(FIPS_OUT, 1'b1, ok);
    wait_done(cyc, ok);
    checks++; if (!ok || cyc != LAT) begin errors++; $display("FAIL inv_latency: got %0d cycles (valid=%b) want %0d", cyc, ok, LAT); end
    checks++; if (out_data !== FIPS_IN) begin errors++; $display("FAIL inv_data: got %h want %h", out_data, FIPS_IN); end
    $display("txn inverse: in=%h out=%h latency=%0d", FIPS_OUT, out_data, cyc);
    take_out();
  endtask

  task automatic test_columns();
    logic [31:0] t_in  [8] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6,
                               32'hd4d4d4d5, 32'h2d26314c, 32'h8e4da1bc, 32'h4d7ebdf8};
    logic        t_inv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_exp [8] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6,
                               32'hd5d5d7d6, 32'h4d7ebdf8, 32'hdb135345, 32'h2d26314c};
    for (int i = 0; i < 8; i++) begin
      bit ok;
      int cyc;
      logic [127:0] want;
      want = {4{t_exp[i]}};
      start_block({4{t_in[i]}}, t_inv[i], ok);
      wait_done(cyc, ok);
      checks++;
      if (!ok || out_data !== want) begin
        errors++;
        $display("FAIL column_%0d: got %h (valid=%b) want %h", i, out_data, ok, want);
      end
      $display("txn column %0d: in=%h inv=%b out=%h", i, t_in[i], t_inv[i], out_data[127:96]);
      take_out();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    start_block(FIPS_IN, 1'b0, ok);
    wait_done(cyc, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_data !== FIPS_OUT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got data=%h in_ready=%b out_valid=%b want %h/0/1",
                 i, out_data, in_ready, out_valid, FIPS_OUT);
      end
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 128'h0123456789abcdef0123456789abcdef;
        in_inv   = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== FIPS_OUT) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b data=%h want 0/1/%h",
               out_valid, in_ready, out_data, FIPS_OUT);
    end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_ghost: got busy=%b want 0", busy); end
    $display("txn backpressure: held out=%h for 10 cycles", out_data);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int cyc;
    start_block(FIPS_IN, 1'b0, ok);
    repeat (2 / CPC) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL midrst_state: got out_valid=%b in_ready=%b busy=%b data=%h want 0/1/0/0",
               out_valid, in_ready, busy, out_data);
    end
    start_block(FIPS_OUT, 1'b1, ok);
    wait_done(cyc, ok);
    checks++; if (!ok || cyc != LAT) begin errors++; $display("FAIL midrst_latency: got %0d cycles (valid=%b) want %0d", cyc, ok, LAT); end
    checks++; if (out_data !== FIPS_IN) begin errors++; $display("FAIL midrst_data: got %h want %h", out_data, FIPS_IN); end
    $display("txn reset mid-run: follow-up out=%h latency=%0d", out_data, cyc);
    take_out();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_columns();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
